muldiv_unit: RTL
================

// Module: muldiv_unit
// PURPOSE
//  Parametrised multi-cycle multiply/divide unit, the sequential companion to the single-cycle ALU.
//  Iterative radix-2 engine with constant WIDTH+1 cycle latency.
//  Uses a valid/ready handshake on both sides; the result is held until it is consumed.
//  Sits beside the ALU in EX. Flags mirror the ALU (zero/negative/overflow) plus divzero.
// PARAMETERS
//  WIDTH  32  operand/result width in bits, >=4
//  TAG_W  4   width of the opaque tag carried from request to result
// PORTS
//  CLK        in   1      clock, rising edge; sole clock
//  nRST       in   1      reset, synchronous, active-low
//  in_valid   in   1      request valid
//  in_ready   out  1      unit can accept (high only in IDLE)
//  op         in   3      000 MULLO, 001 MULHI(s*s), 010 MULHIU, 011 DIV, 100 DIVU, 101 REM, 110 REMU, 111 rsvd
//  porta      in   WIDTH  multiplicand / dividend
//  portb      in   WIDTH  multiplier / divisor
//  tag_in     in   TAG_W  request tag
//  flush      in   1      abort any in-flight or held operation
//  out_valid  out  1      result valid
//  out_ready  in   1      consumer takes result
//  out_port   out  WIDTH  result
//  tag_out    out  TAG_W  tag of result
//  zero       out  1      out_port == 0
//  negative   out  1      out_port[WIDTH-1]
//  overflow   out  1      MULLO: signed product not representable in WIDTH; DIV/REM: MIN / -1
//  divzero    out  1      DIV/DIVU/REM/REMU with portb == 0
//  busy       out  1      state != IDLE
// BEHAVIOUR
//  Clocking: one clock (CLK); nRST synchronous active-low. While nRST=0 at an edge: state=IDLE, out_valid=0,
//   out_port=0, tag_out=0, all flags 0, counter=0. in_ready=1 after reset. Mid-op reset discards the op.
//  FSM: IDLE -> CALC on in_valid&in_ready (operands, op and tag latched; signed ops latch magnitudes + result sign).
//   CALC: one shift-add / restoring-subtract step per cycle, counter 0..WIDTH-1; last step -> FIX.
//   FIX: sign correction, special cases, flag compute -> DONE. DONE: out_valid=1, outputs stable;
//   out_valid&out_ready -> IDLE. A new request is accepted only in IDLE (no same-cycle DONE->accept).
//  Latency: accept at edge k -> out_valid high after edge k+WIDTH+1, for every op, div-by-0 included.
//  Arithmetic: MULLO = low WIDTH of product (sign-agnostic); MULHI = high WIDTH of signed 2W product;
//   MULHIU = high WIDTH unsigned. DIV/REM truncate toward zero; sign(rem) = sign(dividend).
//  Div by zero: DIV/DIVU = all ones, REM/REMU = porta, divzero=1, overflow=0.
//  Signed overflow: DIV MIN/-1 = MIN, REM MIN/-1 = 0, overflow=1.
//  op 111: out_port=0, zero=1, other flags 0, same latency.
//  zero/negative derive from final out_port; overflow/divzero as per PORTS, 0 when not applicable.
//  flush: at the edge, any state -> IDLE, out_valid=0; result dropped. flush outranks in_valid (no accept
//   that cycle). nRST outranks flush.
//  Outputs out_port/tag_out/flags are registered and change only on FIX->DONE or reset.
// TESTING (WIDTH=32)
//  MULLO 7 * 0xFFFFFFFD -> 0xFFFFFFEB, negative=1, overflow=0, out_valid exactly 33 edges after accept
//  MULLO 0x00010000 * 0x00010000 -> 0, zero=1, overflow=1; MULHIU 0xFFFFFFFF^2 -> 0xFFFFFFFE; MULHI same -> 0, zero=1
//  DIV 0xFFFFFFF9 / 2 -> 0xFFFFFFFD; REM same -> 0xFFFFFFFF; DIVU 0xFFFFFFF9 / 2 -> 0x7FFFFFFC
//  DIVU 5/0 -> 0xFFFFFFFF, divzero=1; REMU 5/0 -> 5; DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000, overflow=1; REM -> 0
//  out_ready=0 for 5 cycles in DONE -> out_port/tag_out stable, in_ready=0; tag_in 0xA returns on tag_out
//  flush at CALC cycle 10 -> IDLE next edge, no out_valid; nRST=0 mid-CALC -> all outputs 0 next edge, then new op ok

Source files
------------

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative radix-2 multiply/divide unit, sequential companion to the EX-stage ALU.
// Latency: request accepted at edge k -> out_valid high after edge k+WIDTH+1, for every op.
// Backpressure: result held in DONE until out_ready; in_ready is high only in IDLE.
// Ports: CLK / nRST (sync, active-low) | in_valid, in_ready, op, porta, portb, tag_in (request)
//        out_valid, out_ready, out_port, tag_out, zero, negative, overflow, divzero (result)
//        flush (abort in-flight or held op) | busy (state != IDLE)
module muldiv_unit #(
   parameter int WIDTH = 32,
   parameter int TAG_W = 4
) (
   input  logic             CLK,
   input  logic             nRST,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] porta,
   input  logic [WIDTH-1:0] portb,
   input  logic [TAG_W-1:0] tag_in,
   input  logic             flush,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_port,
   output logic [TAG_W-1:0] tag_out,
   output logic             zero,
   output logic             negative,
   output logic             overflow,
   output logic             divzero,
   output logic             busy
);

   localparam int CNT_W = $clog2(WIDTH);
   localparam logic [WIDTH-1:0] MIN_V = {1'b1, {(WIDTH-1){1'b0}}};

   localparam logic [2:0] OP_MULLO  = 3'b000;
   localparam logic [2:0] OP_MULHI  = 3'b001;
   localparam logic [2:0] OP_MULHIU = 3'b010;
   localparam logic [2:0] OP_DIV    = 3'b011;
   localparam logic [2:0] OP_DIVU   = 3'b100;
   localparam logic [2:0] OP_REM    = 3'b101;
   localparam logic [2:0] OP_REMU   = 3'b110;

   typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

   state_t           r_state;
   state_t           w_next;
   logic [CNT_W-1:0] r_cnt;
   logic [2:0]       r_op;
   logic [TAG_W-1:0] r_tag;
   // r_a: multiplicand or divisor magnitude. {r_hi,r_lo}: product, or remainder/quotient.
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_hi;
   logic [WIDTH-1:0] r_lo;
   logic             r_neg_res;
   logic             r_neg_rem;
   logic             r_dz;
   logic             r_ovf_div;

   logic [WIDTH-1:0] r_out;
   logic [TAG_W-1:0] r_tag_out;
   logic             r_zero;
   logic             r_neg;
   logic             r_ovf;
   logic             r_divz;

   // ---------------- request decode ----------------
   logic             w_accept;
   logic             w_op_div;
   logic             w_op_sgn;
   logic             w_sa;
   logic             w_sb;
   logic [WIDTH-1:0] w_maga;
   logic [WIDTH-1:0] w_magb;

   assign w_accept = in_ready & in_valid & ~flush;
   assign w_op_div = (op >= OP_DIV) && (op <= OP_REMU);
   // MULLO is treated as signed so its overflow flag can be derived from the signed product
   assign w_op_sgn = (op == OP_MULLO) || (op == OP_MULHI) || (op == OP_DIV) || (op == OP_REM);
   assign w_sa     = w_op_sgn & porta[WIDTH-1];
   assign w_sb     = w_op_sgn & portb[WIDTH-1];
   assign w_maga   = w_sa ? -porta : porta;
   assign w_magb   = w_sb ? -portb : portb;

   // ---------------- iteration step ----------------
   logic             w_r_div;
   logic             w_last;
   logic [WIDTH:0]   w_mul_sum;
   logic [WIDTH:0]   w_rem_sh;
   logic [WIDTH-1:0] w_sub;
   logic             w_ge;

   assign w_r_div   = (r_op >= OP_DIV) && (r_op <= OP_REMU);
   assign w_last    = (r_cnt == CNT_W'(WIDTH-1));
   assign w_mul_sum = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_a} : '0);
   assign w_rem_sh  = {r_hi, r_lo[WIDTH-1]};
   assign w_ge      = (w_rem_sh >= {1'b0, r_a});
   // when w_ge holds the difference is below the divisor, so the low WIDTH bits are exact
   assign w_sub     = w_rem_sh[WIDTH-1:0] - r_a;

   // ---------------- sign fix / special cases ----------------
   logic [2*WIDTH-1:0] w_prod;
   logic [WIDTH-1:0]   w_quo;
   logic [WIDTH-1:0]   w_rem;
   logic [WIDTH-1:0]   w_res;
   logic               w_res_ovf;

   assign w_prod = r_neg_res ? -{r_hi, r_lo} : {r_hi, r_lo};
   // divide by zero naturally leaves the dividend magnitude in r_hi, so REM/REMU need no override
   assign w_quo  = r_dz ? '1 : (r_neg_res ? -r_lo : r_lo);
   assign w_rem  = r_neg_rem ? -r_hi : r_hi;

   always_comb begin
      w_res     = '0;
      w_res_ovf = 1'b0;
      case (r_op)
         OP_MULLO: begin
            w_res     = w_prod[WIDTH-1:0];
            w_res_ovf = (w_prod[2*WIDTH-1:WIDTH] != {WIDTH{w_prod[WIDTH-1]}});
         end
         OP_MULHI, OP_MULHIU: w_res = w_prod[2*WIDTH-1:WIDTH];
         // MIN / -1 falls out of the magnitude path as MIN with remainder 0
         OP_DIV: begin
            w_res     = w_quo;
            w_res_ovf = r_ovf_div;
         end
         OP_DIVU: w_res = w_quo;
         OP_REM: begin
            w_res     = w_rem;
            w_res_ovf = r_ovf_div;
         end
         OP_REMU: w_res = w_rem;
         default: w_res = '0;
      endcase
   end

   // ---------------- FSM ----------------
   always_ff @(posedge CLK) begin
      if (!nRST) r_state <= S_IDLE;
      else       r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      if (flush) begin
         w_next = S_IDLE;
      end else begin
         case (r_state)
            S_IDLE:  if (in_valid)  w_next = S_CALC;
            S_CALC:  if (w_last)    w_next = S_FIX;
            S_FIX:                  w_next = S_DONE;
            S_DONE:  if (out_ready) w_next = S_IDLE;
            default:                w_next = S_IDLE;
         endcase
      end
   end

   always_comb begin
      in_ready  = 1'b0;
      out_valid = 1'b0;
      busy      = 1'b1;
      case (r_state)
         S_IDLE: begin
            in_ready = 1'b1;
            busy     = 1'b0;
         end
         S_DONE:  out_valid = 1'b1;
         default: ;
      endcase
   end

   // ---------------- datapath ----------------
   always_ff @(posedge CLK) begin
      if (!nRST) begin
         r_cnt     <= '0;
         r_op      <= '0;
         r_tag     <= '0;
         r_a       <= '0;
         r_hi      <= '0;
         r_lo      <= '0;
         r_neg_res <= 1'b0;
         r_neg_rem <= 1'b0;
         r_dz      <= 1'b0;
         r_ovf_div <= 1'b0;
         r_out     <= '0;
         r_tag_out <= '0;
         r_zero    <= 1'b0;
         r_neg     <= 1'b0;
         r_ovf     <= 1'b0;
         r_divz    <= 1'b0;
      end else begin
         if (flush) begin
            r_cnt <= '0;
         end else if (w_accept) begin
            r_cnt     <= '0;
            r_op      <= op;
            r_tag     <= tag_in;
            r_hi      <= '0;
            r_a       <= w_op_div ? w_magb : w_maga;
            r_lo      <= w_op_div ? w_maga : w_magb;
            r_neg_res <= w_sa ^ w_sb;
            r_neg_rem <= w_sa;
            r_dz      <= w_op_div && (portb == '0);
            r_ovf_div <= ((op == OP_DIV) || (op == OP_REM)) && (porta == MIN_V) && (portb == '1);
         end else if (r_state == S_CALC) begin
            r_cnt <= w_last ? '0 : r_cnt + 1'b1;
            if (w_r_div) begin
               // restoring division: quotient bits shift in at the bottom of r_lo
               if (w_ge) begin
                  r_hi <= w_sub;
                  r_lo <= {r_lo[WIDTH-2:0], 1'b1};
               end else begin
                  r_hi <= w_rem_sh[WIDTH-1:0];
                  r_lo <= {r_lo[WIDTH-2:0], 1'b0};
               end
            end else begin
               // shift-add: multiplier bits consumed from r_lo[0], product bits enter at the top
               r_hi <= w_mul_sum[WIDTH:1];
               r_lo <= {w_mul_sum[0], r_lo[WIDTH-1:1]};
            end
         end

         if ((r_state == S_FIX) && !flush) begin
            r_out     <= w_res;
            r_tag_out <= r_tag;
            r_zero    <= (w_res == '0);
            r_neg     <= w_res[WIDTH-1];
            r_ovf     <= w_res_ovf;
            r_divz    <= r_dz;
         end
      end
   end

   assign out_port = r_out;
   assign tag_out  = r_tag_out;
   assign zero     = r_zero;
   assign negative = r_neg;
   assign overflow = r_ovf;
   assign divzero  = r_divz;

endmodule
